vram_prefetch: RTL and testbench
================================

// Module: vram_prefetch
// PURPOSE
//  Wishbone master that streams the frame buffer from VRAM into a word FIFO and unpacks it into 4-bit pixels.
//  Sits between system memory and the VGA pixel/timing stage in the graphic card.
//  The timing stage pulls one pixel per pix_rd strobe; the block keeps the FIFO topped up ahead of demand.
// PARAMETERS
//  FIFO_DEPTH   16     FIFO depth in 32-bit words; power of 2, >=4
//  FRAME_WORDS  38400  words per frame (640*480 pixels, 4 bpp, 8 pixels/word)
// PORTS
//  clk          in   1   system clock; all logic on posedge
//  rst_n        in   1   synchronous, active-low reset
//  enable       in   1   fetch enable (status_register[0])
//  base_addr    in   32  VRAM base byte address; sampled at frame_start
//  frame_start  in   1   1-cycle pulse at the start of each frame
//  pix_rd       in   1   1-cycle strobe: consumer takes the current pixel
//  pix_color    out  4   current pixel; 0 when pix_valid=0
//  pix_valid    out  1   FIFO non-empty
//  underflow    out  1   sticky: pix_rd seen while pix_valid=0; cleared by frame_start
//  wb_adr_o     out  32  read address, word aligned
//  wb_dat_o     out  32  tied 0
//  wb_sel_o     out  4   tied 4'hF
//  wb_we_o      out  1   tied 0
//  wb_cyc_o     out  1   bus cycle
//  wb_stb_o     out  1   strobe; equal to wb_cyc_o
//  wb_dat_i     in   32  read data
//  wb_ack_i     in   1   acknowledge
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - Outputs: cyc/stb=0, adr=0, pix_valid=0, pix_color=0, underflow=0.
//   - Internal: FIFO empty, word_cnt=0, nib_idx=0, state=IDLE.
//   - Reset mid-cycle drops cyc/stb at once; the whole bus is in reset at the same time.
//  FSM states:
//   - IDLE: go to REQ when enable && word_cnt<FRAME_WORDS && fifo_cnt<FIFO_DEPTH.
//   - REQ: cyc=stb=1, adr=base_lat+4*word_cnt. On ack: push wb_dat_i, word_cnt++, return to IDLE.
//     One outstanding access at most; stb drops for >=1 cycle between accesses.
//   - FLUSH: entered from REQ when frame_start arrives or enable drops. Keeps cyc/stb until ack,
//     discards the data, then clears and goes to IDLE.
//  Clear (frame_start in IDLE, or on leaving FLUSH):
//   - FIFO emptied, word_cnt=0, nib_idx=0, base_lat<=base_addr.
//   - underflow<=0 on frame_start.
//   - A frame_start during REQ is remembered and the clear is applied on leaving FLUSH.
//  Enable low: no new requests; an outstanding access finishes through FLUSH. FIFO contents are kept.
//  End of frame: once word_cnt==FRAME_WORDS, no further fetches until the next frame_start.
//  Unpack:
//   - pix_color = head[31-4*nib_idx -: 4]; pixel 0 is the MSB nibble.
//   - pix_rd && pix_valid: nib_idx++; when nib_idx==7, pop the word and set nib_idx<=0.
//   - pix_rd && !pix_valid: underflow<=1, nothing is popped, pix_color stays 0.
//  Simultaneous push and pop: both happen, fifo_cnt unchanged. Push when full cannot occur (request gate).
//  Latency: ack -> push registered -> pix_valid high on the next cycle.
//  Widths: word_cnt is 16 bits; address add is 32-bit wrap-around modulo 2^32.
// CONFIGURATION
//  VRAM_PREFETCH_STATS_EN:
//   - Defined: adds output underflow_cnt [15:0]. Increments on each pix_rd with pix_valid=0,
//     saturates at 16'hFFFF, cleared only by reset.
//   - Undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Shared header gc_defs.vh: GC_BPP=4, GC_PIX_PER_WORD=8, GC_WB_SEL_ALL=4'hF, FSM state encodings.
//  One sub-module: gc_sync_fifo (WIDTH, DEPTH; push/pop/clear, count/full/empty; sync active-low reset).
// TESTING
//  1. base=0x40800000, enable=1, zero-wait ack -> adr 0x40800000, 0x40800004, ...; FIFO fills to 16 and stops.
//  2. Word 0x0123_4567 in FIFO, 8 pix_rd -> pix_color 0,1,2,...,7; word popped after the 8th strobe.
//  3. pix_rd with FIFO empty -> underflow=1, pix_color=0; next frame_start clears underflow
//     (STATS_EN: underflow_cnt=1).
//  4. frame_start during REQ with ack delayed 5 cycles -> cyc held until ack, data dropped,
//     next adr = new base_addr.
//  5. FRAME_WORDS=4 -> exactly 4 accesses, then idle until frame_start; push+pop in the same cycle keeps count.
//  6. rst_n=0 during REQ -> next cycle cyc=stb=0, pix_valid=0, adr=0.

Source files
------------

// File: rtl/vram_prefetch_pkg.sv
// Shared constants and FSM encoding for the VRAM prefetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vram_prefetch_pkg;

    localparam int         GC_BPP          = 4;
    localparam int         GC_PIX_PER_WORD = 8;
    localparam logic [3:0] GC_WB_SEL_ALL   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/gc_sync_fifo.sv
// Synchronous show-ahead FIFO with a clear that empties it in one cycle.
// Latency: push visible at head/count on the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; clear wins over both.
module gc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    input  logic                   clear,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push+pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/vram_prefetch.sv
// Wishbone read master streaming the frame buffer into a word FIFO, unpacked to 4-bit pixels.
// Latency: ack -> word pushed at that edge -> pix_valid high the following cycle.
// Backpressure: no request while the FIFO is full; optional VRAM_PREFETCH_STATS_EN adds underflow_cnt.
module vram_prefetch
    import vram_prefetch_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_WORDS = 38400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [31:0]       base_addr,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [GC_BPP-1:0] pix_color,
    output logic              pix_valid,
    output logic              underflow,
    output logic [31:0]       wb_adr_o,
    output logic [31:0]       wb_dat_o,
    output logic [3:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_ack_i
`ifdef VRAM_PREFETCH_STATS_EN
    ,
    output logic [15:0]       underflow_cnt
`endif
);

    localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_NIB = 3'(GC_PIX_PER_WORD - 1);

    state_t          state;
    state_t          state_nxt;
    logic            cyc;
    logic            push;
    logic            clear;
    logic            pop;
    logic            pix_take;
    logic [15:0]     word_cnt;
    logic [2:0]      nib_idx;
    logic [4:0]      nib_lo;
    logic [31:0]     base_lat;
    logic [31:0]     base_pend;
    logic            fs_pend;
    logic [31:0]     fifo_head;
    logic [CW-1:0]   fifo_cnt;
    logic            fifo_full_unused;  // the count gate already keeps pushes off a full FIFO
    logic            fifo_empty;
    logic            fetch_ok;

    assign fetch_ok = enable && (word_cnt < 16'(FRAME_WORDS)) && (fifo_cnt < CW'(FIFO_DEPTH));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state, bus strobe, push and clear decode.
    // A frame_start that coincides with an ack drops that word and clears straight away;
    // an enable drop coinciding with an ack lets the word land normally.
    always_comb begin
        state_nxt = state;
        cyc       = 1'b0;
        push      = 1'b0;
        clear     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (frame_start)   clear     = 1'b1;
                else if (fetch_ok) state_nxt = ST_REQ;
            end
            ST_REQ: begin
                cyc = 1'b1;
                if (frame_start) begin
                    if (wb_ack_i) begin
                        clear     = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_FLUSH;
                    end
                end else if (wb_ack_i) begin
                    push      = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (!enable) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                cyc = 1'b1;
                if (wb_ack_i) begin
                    clear     = fs_pend || frame_start;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame bookkeeping: word counter, base latch and a frame_start deferred past a flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            base_lat  <= '0;
            base_pend <= '0;
            fs_pend   <= 1'b0;
        end else if (clear) begin
            word_cnt  <= '0;
            base_lat  <= frame_start ? base_addr : base_pend;
            fs_pend   <= 1'b0;
        end else begin
            if (push) word_cnt <= word_cnt + 16'd1;
            if (frame_start) begin
                fs_pend   <= 1'b1;
                base_pend <= base_addr;
            end
        end
    end

    gc_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (wb_dat_i),
        .pop      (pop),
        .clear    (clear),
        .head     (fifo_head),
        .count    (fifo_cnt),
        .full     (fifo_full_unused),
        .empty    (fifo_empty)
    );

    // Pixel 0 sits in the top nibble, so the low bit of the slice is 4*(7-nib_idx).
    assign nib_lo    = {~nib_idx, 2'b00};
    assign pix_valid = !fifo_empty;
    assign pix_color = fifo_empty ? '0 : fifo_head[nib_lo +: GC_BPP];
    assign pix_take  = pix_rd && !fifo_empty;
    assign pop       = pix_take && (nib_idx == LAST_NIB);

    // Nibble pointer within the head word; wraps to 0 as the word is popped.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) nib_idx <= '0;
        else if (pix_take)   nib_idx <= nib_idx + 3'd1;
    end

    // Sticky underflow flag; a same-cycle underflow survives the frame_start clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else begin
            if (frame_start)           underflow <= 1'b0;
            if (pix_rd && fifo_empty)  underflow <= 1'b1;
        end
    end

`ifdef VRAM_PREFETCH_STATS_EN
    // Saturating count of starved pixel reads, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n)
            underflow_cnt <= '0;
        else if (pix_rd && fifo_empty && (underflow_cnt != 16'hFFFF))
            underflow_cnt <= underflow_cnt + 16'd1;
    end
`endif

    assign wb_adr_o = base_lat + {14'd0, word_cnt, 2'b00};
    assign wb_dat_o = '0;
    assign wb_sel_o = GC_WB_SEL_ALL;
    assign wb_we_o  = 1'b0;
    assign wb_cyc_o = cyc;
    assign wb_stb_o = cyc;

endmodule

// File: tb/tb_vram_prefetch.sv
// Directed bench for vram_prefetch with a small Wishbone slave model of configurable ack delay.
// Latency: n/a.
// Backpressure: n/a.
module tb_vram_prefetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] base_addr;
    logic        frame_start;
    logic        pix_rd;
    logic [3:0]  pix_color;
    logic        pix_valid;
    logic        underflow;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
`ifdef VRAM_PREFETCH_STATS_EN
    logic [15:0] underflow_cnt;
`endif

    int          total = 0;
    int          bad   = 0;
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    logic [31:0] acc_q[$];

    always #5 clk = ~clk;

    vram_prefetch #(
        .FIFO_DEPTH  (16),
        .FRAME_WORDS (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .base_addr   (base_addr),
        .frame_start (frame_start),
        .pix_rd      (pix_rd),
        .pix_color   (pix_color),
        .pix_valid   (pix_valid),
        .underflow   (underflow),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_we_o     (wb_we_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i)
`ifdef VRAM_PREFETCH_STATS_EN
        ,
        .underflow_cnt (underflow_cnt)
`endif
    );

    // Memory content: word index i (address bits [9:2]) holds 0x01234567 + i*0x11111111.
    function automatic logic [31:0] word_at(input int idx);
        return 32'h0123_4567 + 32'(idx) * 32'h1111_1111;
    endfunction

    function automatic logic [3:0] nib_of(input logic [31:0] w, input int n);
        logic [31:0] s;
        s = w >> (28 - 4 * n);
        return s[3:0];
    endfunction

    // Slave model: ack after ack_delay cycles of strobe, data from the address.
    always @(posedge clk) begin
        if (!wb_stb_o || wb_ack_i) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end
    assign wb_ack_i = wb_stb_o && (wait_cnt >= ack_delay);
    assign wb_dat_i = word_at(int'(wb_adr_o[9:2]));

    // Log of completed access addresses.
    always @(posedge clk) begin
        if (rst_n && wb_cyc_o && wb_ack_i) acc_q.push_back(wb_adr_o);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input logic want, input string nm);
        int n = 0;
        while (wb_cyc_o !== want && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(nm, {31'd0, wb_cyc_o}, {31'd0, want});
    endtask

    typedef struct {
        logic       rd;
        logic [3:0] col;
        logic       vld;
    } vec_t;

    vec_t vec[17];

    initial begin
        int wi;
        int ni;
        int n;

        // Pixel sequence of words 0 and 1, then the first pixel of word 2.
        vec[0]  = '{1'b1, 4'h0, 1'b1};  vec[1]  = '{1'b1, 4'h1, 1'b1};
        vec[2]  = '{1'b1, 4'h2, 1'b1};  vec[3]  = '{1'b1, 4'h3, 1'b1};
        vec[4]  = '{1'b1, 4'h4, 1'b1};  vec[5]  = '{1'b1, 4'h5, 1'b1};
        vec[6]  = '{1'b1, 4'h6, 1'b1};  vec[7]  = '{1'b1, 4'h7, 1'b1};
        vec[8]  = '{1'b1, 4'h1, 1'b1};  vec[9]  = '{1'b1, 4'h2, 1'b1};
        vec[10] = '{1'b1, 4'h3, 1'b1};  vec[11] = '{1'b1, 4'h4, 1'b1};
        vec[12] = '{1'b1, 4'h5, 1'b1};  vec[13] = '{1'b1, 4'h6, 1'b1};
        vec[14] = '{1'b1, 4'h7, 1'b1};  vec[15] = '{1'b1, 4'h8, 1'b1};
        vec[16] = '{1'b0, 4'h2, 1'b1};

        rst_n = 1'b0; enable = 1'b0; base_addr = '0; frame_start = 1'b0; pix_rd = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cyc",   {31'd0, wb_cyc_o},  32'd0);
        chk("rst_stb",   {31'd0, wb_stb_o},  32'd0);
        chk("rst_adr",   wb_adr_o,           32'd0);
        chk("rst_valid", {31'd0, pix_valid}, 32'd0);
        chk("rst_color", {28'd0, pix_color}, 32'd0);
        chk("rst_uflow", {31'd0, underflow}, 32'd0);
        chk("tie_sel",   {28'd0, wb_sel_o},  32'hF);
        chk("tie_we",    {31'd0, wb_we_o},   32'd0);

        // Fill: zero-wait slave, FIFO stops at 16 words.
        acc_q.delete();
        rst_n = 1'b1; enable = 1'b1; base_addr = 32'h4080_0000; frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (60) @(negedge clk);
        chk("fill_count", 32'(acc_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < acc_q.size(); i++)
            chk("fill_adr", acc_q[i], 32'h4080_0000 + 32'(4 * i));
        chk("fill_idle",  {31'd0, wb_cyc_o},  32'd0);
        chk("fill_valid", {31'd0, pix_valid}, 32'd1);

        // Unpack table: MSB nibble first, word popped after the eighth strobe.
        for (int i = 0; i < 17; i++) begin
            chk("unpack_col", {28'd0, pix_color}, {28'd0, vec[i].col});
            chk("unpack_vld", {31'd0, pix_valid}, {31'd0, vec[i].vld});
            pix_rd = vec[i].rd;
            @(negedge clk);
        end
        pix_rd = 1'b0;

        // Drain to end of frame (20 words), checking every pixel in order.
        wi = 2; ni = 0;
        for (int k = 0; k < 600; k++) begin
            if (!pix_valid) begin
                pix_rd = 1'b0;
                break;
            end
            chk("drain_px", {28'd0, pix_color}, {28'd0, nib_of(word_at(wi), ni)});
            pix_rd = 1'b1;
            ni++;
            if (ni == 8) begin
                ni = 0;
                wi++;
            end
            @(negedge clk);
        end
        pix_rd = 1'b0;
        chk("drain_words", 32'(wi), 32'd20);
        repeat (30) @(negedge clk);
        chk("eof_count", 32'(acc_q.size()), 32'd20);
        for (int i = 16; i < 20 && i < acc_q.size(); i++)
            chk("eof_adr", acc_q[i], 32'h4080_0000 + 32'(4 * i));
        chk("eof_idle", {31'd0, wb_cyc_o}, 32'd0);

        // Underflow: strobe with empty FIFO.
        pix_rd = 1'b1;
        @(negedge clk);
        pix_rd = 1'b0;
        chk("uf_flag",  {31'd0, underflow}, 32'd1);
        chk("uf_color", {28'd0, pix_color}, 32'd0);
        @(negedge clk);
        chk("uf_sticky", {31'd0, underflow}, 32'd1);
`ifdef VRAM_PREFETCH_STATS_EN
        chk("uf_cnt", {16'd0, underflow_cnt}, 32'd1);
`endif

        // New frame clears underflow; then frame_start during a slow access.
        ack_delay = 5;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("fs_uf_clear", {31'd0, underflow}, 32'd0);
        wait_cyc(1'b1, "fl_req_start");
        acc_q.delete();
        frame_start = 1'b1; base_addr = 32'h5000_0000;
        @(negedge clk);
        frame_start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("fl_hold", {31'd0, wb_cyc_o}, 32'd1);
            @(negedge clk);
        end
        wait_cyc(1'b0, "fl_end");
        chk("fl_dropped",  {31'd0, pix_valid}, 32'd0);
        chk("fl_acc_num",  32'(acc_q.size()), 32'd1);
        if (acc_q.size() > 0) chk("fl_old_adr", acc_q[0], 32'h4080_0000);
        n = 0;
        while (acc_q.size() < 2 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("nf_acc_num", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() > 1) chk("nf_adr", acc_q[1], 32'h5000_0000);
        chk("nf_valid", {31'd0, pix_valid}, 32'd1);
        chk("nf_color", {28'd0, pix_color}, 32'd0);

        // Reset in the middle of an access.
        wait_cyc(1'b1, "rr_req_start");
        rst_n = 1'b0;
        @(negedge clk);
        chk("rr_cyc",   {31'd0, wb_cyc_o},  32'd0);
        chk("rr_stb",   {31'd0, wb_stb_o},  32'd0);
        chk("rr_adr",   wb_adr_o,           32'd0);
        chk("rr_valid", {31'd0, pix_valid}, 32'd0);
`ifdef VRAM_PREFETCH_STATS_EN
        chk("rr_cnt", {16'd0, underflow_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
